axi_master_cmd_sequencer: RTL and testbench

AXI_MASTER_CMD_SEQUENCER -- requirements
Module: axi_master_cmd_sequencer

---
 rtl/axi_master_cmd_sequencer_if.sv | 26 ++
 rtl/axi_master_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_axi_master_cmd_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_cmd_sequencer_if.sv
// axi_master_cmd_sequencer_if: command and status bus between the sequencer and the downstream AXI master.
interface axi_master_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mst_go;
    logic                  mst_rnw;
    logic                  mst_increment_burst;
    logic [31:0]           mst_address;
    logic [7:0]            mst_burst_length;
    logic [6:0]            mst_burst_size;
    logic [DATA_WIDTH-1:0] mst_write_data;
    logic                  mst_busy;
    logic                  mst_done;
    logic                  mst_error;
    logic                  mst_read_data_valid;
    logic                  mst_write_data_valid;
    logic [DATA_WIDTH-1:0] mst_read_data;
    modport master (
        output mst_go, mst_rnw, mst_increment_burst, mst_address, mst_burst_length, mst_burst_size, mst_write_data,
        input  mst_busy, mst_done, mst_error, mst_read_data_valid, mst_write_data_valid, mst_read_data
    );
    modport slave (
        input  mst_go, mst_rnw, mst_increment_burst, mst_address, mst_burst_length, mst_burst_size, mst_write_data,
        output mst_busy, mst_done, mst_error, mst_read_data_valid, mst_write_data_valid, mst_read_data
    );
endinterface

// File: rtl/axi_master_cmd_sequencer.sv
// axi_master_cmd_sequencer: queues commands and runs them one at a time on an AXI master, reporting per-command status.
module axi_master_cmd_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       m_axi_aclk,
    input  logic                       m_axi_aresetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rnw,
    input  logic [31:0]                cmd_address,
    input  logic [7:0]                 cmd_burst_length,
    input  logic [6:0]                 cmd_burst_size,
    input  logic                       cmd_increment,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata_seed,
    axi_master_cmd_sequencer_if.master mst,
    output logic                       rsp_valid,
    output logic                       rsp_error,
    output logic                       rsp_timeout,
    output logic                       rsp_rnw,
    output logic [8:0]                 rsp_beats,
    output logic [DATA_WIDTH-1:0]      rsp_checksum,
    output logic [15:0]                cmd_count,
    output logic [15:0]                err_count,
    output logic [1:0]                 state_out
);
    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RELEASE = 2'b10, REPORT = 2'b11} state_t;
    typedef struct packed {
        logic                  rnw;
        logic [31:0]           addr;
        logic [7:0]            len;
        logic [6:0]            size;
        logic                  incr;
        logic [DATA_WIDTH-1:0] seed;
    } cmd_t;
    localparam int AW = $clog2(CMD_DEPTH);

    cmd_t                  mem [CMD_DEPTH];
    cmd_t                  hold;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    state_t                state;
    logic                  go_q, err_q, to_q;
    logic [8:0]            beat;
    logic [DATA_WIDTH-1:0] csum;
    logic [31:0]           wd;
    logic                  push, pop, beat_ev;

    assign cmd_ready = m_axi_aresetn && count != (AW+1)'(CMD_DEPTH);
    assign push      = cmd_valid && cmd_ready;
    // never start a command while the master is still showing done from the previous one
    assign pop       = state == IDLE && count != '0 && !mst.mst_done;
    assign beat_ev   = hold.rnw ? mst.mst_read_data_valid : mst.mst_write_data_valid;

    assign mst.mst_go              = go_q;
    assign mst.mst_rnw             = hold.rnw;
    assign mst.mst_address         = hold.addr;
    assign mst.mst_burst_length    = hold.len;
    assign mst.mst_burst_size      = hold.size;
    assign mst.mst_increment_burst = hold.incr;
    assign mst.mst_write_data      = hold.seed + DATA_WIDTH'(beat);
    assign state_out               = state;

    always_ff @(posedge m_axi_aclk) begin
        if (push) mem[wr_ptr] <= '{cmd_rnw, cmd_address, cmd_burst_length, cmd_burst_size, cmd_increment, cmd_wdata_seed};
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            hold         <= '0;
            go_q         <= 1'b0;
            err_q        <= 1'b0;
            to_q         <= 1'b0;
            beat         <= '0;
            csum         <= '0;
            wd           <= '0;
            rsp_valid    <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_rnw      <= 1'b0;
            rsp_beats    <= '0;
            rsp_checksum <= '0;
            cmd_count    <= '0;
            err_count    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (pop) begin
                    hold  <= mem[rd_ptr];
                    beat  <= '0;
                    csum  <= '0;
                    wd    <= '0;
                    err_q <= 1'b0;
                    to_q  <= 1'b0;
                    go_q  <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (beat_ev && beat != 9'd256) beat <= beat + 9'd1;
                    if (hold.rnw && mst.mst_read_data_valid) csum <= csum ^ mst.mst_read_data;
                    wd <= wd + 32'd1;
                    if (mst.mst_done) begin
                        err_q <= mst.mst_error;
                        go_q  <= 1'b0;
                        state <= RELEASE;
                    end else if (wd == 32'(TIMEOUT_CYCLES - 1)) begin
                        to_q  <= 1'b1;
                        err_q <= 1'b1;
                        go_q  <= 1'b0;
                        state <= RELEASE;
                    end
                end
                // after a watchdog abort the master must also have gone idle before reporting
                RELEASE: if (!mst.mst_done && (!to_q || !mst.mst_busy)) begin
                    rsp_valid    <= 1'b1;
                    rsp_error    <= err_q;
                    rsp_timeout  <= to_q;
                    rsp_rnw      <= hold.rnw;
                    rsp_beats    <= beat;
                    rsp_checksum <= csum;
                    cmd_count    <= cmd_count + 16'd1;
                    if (err_q) err_count <= err_count + 16'd1;
                    state        <= REPORT;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_master_cmd_sequencer.sv
// tb_axi_master_cmd_sequencer: randomized and directed checks against a behavioural command/response model.
module tb_axi_master_cmd_sequencer;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    typedef struct {
        logic             rnw;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [6:0]       size;
        logic             incr;
        logic [31:0]      seed;
        int               mode;
        int               hang_beats;
        logic [5:0][31:0] rd;
    } beh_t;
    typedef struct {
        logic        rnw;
        logic        err;
        logic        to;
        logic [8:0]  beats;
        logic [31:0] csum;
    } exp_t;

    logic m_axi_aclk = 1'b0;
    logic m_axi_aresetn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0, cmd_increment = 1'b0;
    logic [31:0] cmd_address = '0;
    logic [7:0] cmd_burst_length = '0;
    logic [6:0] cmd_burst_size = '0;
    logic [DW-1:0] cmd_wdata_seed = '0;
    logic rsp_valid, rsp_error, rsp_timeout, rsp_rnw;
    logic [8:0] rsp_beats;
    logic [DW-1:0] rsp_checksum;
    logic [15:0] cmd_count, err_count;
    logic [1:0] state_out;

    axi_master_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    axi_master_cmd_sequencer #(.DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_address(cmd_address),
        .cmd_burst_length(cmd_burst_length), .cmd_burst_size(cmd_burst_size), .cmd_increment(cmd_increment),
        .cmd_wdata_seed(cmd_wdata_seed), .mst(bus),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_rnw(rsp_rnw),
        .rsp_beats(rsp_beats), .rsp_checksum(rsp_checksum), .cmd_count(cmd_count), .err_count(err_count),
        .state_out(state_out)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    int n_checks = 0, n_fail = 0;
    int pushed_n = 0, started_n = 0, beats_driven = 0;
    logic [15:0] exp_cmd = '0, exp_err = '0;
    logic [31:0] last_wdata = '0;
    logic saw_not_ready = 1'b0, abort = 1'b0, prev_rv = 1'b0;
    beh_t beh_q[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t expect_of(input beh_t b);
        exp_t e;
        int n;
        n = b.mode == 2 ? b.hang_beats : int'(b.len) + 1;
        e.rnw = b.rnw;
        e.err = b.mode != 0;
        e.to = b.mode == 2;
        e.beats = 9'(n);
        e.csum = '0;
        if (b.rnw) for (int i = 0; i < n; i++) e.csum ^= b.rd[i];
        return e;
    endfunction

    function automatic beh_t mk(input logic rnw, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] seed, input int mode, input int hang);
        beh_t b;
        b.rnw = rnw; b.addr = addr; b.len = len; b.size = 7'($urandom_range(127, 0));
        b.incr = 1'($urandom_range(1, 0)); b.seed = seed; b.mode = mode; b.hang_beats = hang;
        for (int i = 0; i < 6; i++) b.rd[i] = $urandom;
        return b;
    endfunction

    function automatic beh_t mk_rand();
        int r;
        r = $urandom_range(99, 0);
        return mk(1'($urandom_range(1, 0)), $urandom, 8'($urandom_range(5, 0)), $urandom,
                  r < 70 ? 0 : (r < 85 ? 1 : 2), $urandom_range(3, 0));
    endfunction

    task automatic push(input beh_t b);
        logic r;
        int t;
        @(negedge m_axi_aclk);
        cmd_valid = 1'b1; cmd_rnw = b.rnw; cmd_address = b.addr; cmd_burst_length = b.len;
        cmd_burst_size = b.size; cmd_increment = b.incr; cmd_wdata_seed = b.seed;
        t = 0;
        forever begin
            r = cmd_ready;
            @(posedge m_axi_aclk);
            if (r) break;
            @(negedge m_axi_aclk);
            t++;
            if (t > 300) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        pushed_n++;
        beh_q.push_back(b);
        exp_q.push_back(expect_of(b));
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        @(negedge m_axi_aclk);
        while (!rsp_valid && t < 200) begin
            @(negedge m_axi_aclk);
            t++;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge m_axi_aclk);
            t++;
        end
        chk("drain_all_responses", exp_q.size(), 0);
    endtask

    // Behavioural AXI master: serves each command as described by its entry in beh_q.
    task automatic step();
        @(posedge m_axi_aclk);
        #1;
        if (!m_axi_aresetn) abort = 1'b1;
    endtask

    task automatic clr();
        bus.mst_busy = 1'b0; bus.mst_done = 1'b0; bus.mst_error = 1'b0;
        bus.mst_read_data_valid = 1'b0; bus.mst_write_data_valid = 1'b0; bus.mst_read_data = '0;
    endtask

    task automatic serve();
        beh_t b;
        int n;
        b = beh_q.pop_front();
        started_n++;
        abort = 1'b0;
        beats_driven = 0;
        chk("mst_address", bus.mst_address, b.addr);
        chk("mst_rnw", bus.mst_rnw, b.rnw);
        chk("mst_burst_length", bus.mst_burst_length, b.len);
        chk("mst_burst_size", bus.mst_burst_size, b.size);
        chk("mst_increment_burst", bus.mst_increment_burst, b.incr);
        bus.mst_busy = 1'b1;
        n = b.mode == 2 ? b.hang_beats : int'(b.len) + 1;
        for (int i = 0; i < n && !abort; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                step();
                if (abort) break;
            end
            chk("go_held", bus.mst_go, 1);
            chk("address_held", bus.mst_address, b.addr);
            if (b.rnw) begin
                bus.mst_read_data_valid = 1'b1;
                bus.mst_read_data = b.rd[i];
            end else begin
                bus.mst_write_data_valid = 1'b1;
                chk("mst_write_data", bus.mst_write_data, b.seed + 32'(i));
                last_wdata = bus.mst_write_data;
            end
            beats_driven++;
            if (i == n - 1 && b.mode != 2 && $urandom_range(1, 0) == 1) begin
                bus.mst_done = 1'b1;
                bus.mst_error = b.mode == 1;
            end
            step();
            bus.mst_read_data_valid = 1'b0;
            bus.mst_write_data_valid = 1'b0;
        end
        if (!abort && b.mode != 2) begin
            if (!bus.mst_done) begin
                bus.mst_done = 1'b1;
                bus.mst_error = b.mode == 1;
                step();
            end
            if (!abort && $urandom_range(1, 0) == 1) step();
        end else if (!abort) begin
            for (int t = 0; t < 40 && bus.mst_go && !abort; t++) step();
            repeat ($urandom_range(3, 0)) if (!abort) step();
        end
        clr();
    endtask

    initial begin
        clr();
        forever begin
            step();
            if (m_axi_aresetn && bus.mst_go) begin
                if (beh_q.size() == 0) chk("unexpected_go", 1, 0);
                else serve();
            end
        end
    end

    // Compare process: every cycle out of reset, check handshake occupancy, go/state relation and responses.
    always @(negedge m_axi_aclk) begin
        if (m_axi_aresetn) begin
            chk("go_vs_issue_state", bus.mst_go, state_out == 2'b01);
            chk("cmd_ready_occupancy", cmd_ready, (pushed_n - started_n) < DEPTH);
            if (cmd_valid && !cmd_ready) saw_not_ready = 1'b1;
            if (rsp_valid) begin
                chk("rsp_single_pulse", prev_rv, 0);
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    exp_cmd = exp_cmd + 16'd1;
                    if (e.err) exp_err = exp_err + 16'd1;
                    chk("rsp_rnw", rsp_rnw, e.rnw);
                    chk("rsp_error", rsp_error, e.err);
                    chk("rsp_timeout", rsp_timeout, e.to);
                    chk("rsp_beats", rsp_beats, e.beats);
                    chk("rsp_checksum", rsp_checksum, e.csum);
                    chk("cmd_count", cmd_count, exp_cmd);
                    chk("err_count", err_count, exp_err);
                end
            end
            prev_rv = rsp_valid;
        end else prev_rv = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beh_t b;
        int hi, t;
        repeat (3) @(negedge m_axi_aclk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_go", bus.mst_go, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_count", cmd_count, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_state", state_out, 0);
        m_axi_aresetn = 1'b1;
        @(negedge m_axi_aclk);
        chk("ready_after_reset", cmd_ready, 1);

        push(mk(1'b0, 32'h1000, 8'd3, 32'hA0, 0, 0));
        @(negedge m_axi_aclk);
        chk("go_low_1_cycle", bus.mst_go, 0);
        @(negedge m_axi_aclk);
        chk("go_high_2_cycles", bus.mst_go, 1);
        wait_rsp();
        chk("wr_beats", rsp_beats, 4);
        chk("wr_error", rsp_error, 0);
        chk("wr_cmd_count", cmd_count, 1);
        chk("wr_last_data", last_wdata, 32'hA3);

        b = mk(1'b1, 32'h2000, 8'd1, 32'h0, 0, 0);
        b.rd[0] = 32'h0F0F0F0F;
        b.rd[1] = 32'hFF00FF00;
        push(b);
        wait_rsp();
        chk("rd_checksum", rsp_checksum, 32'hF00FF00F);
        chk("rd_beats", rsp_beats, 2);
        chk("rd_rnw", rsp_rnw, 1);

        push(mk(1'b0, 32'h3000, 8'd0, 32'h5, 1, 0));
        push(mk(1'b1, 32'h3100, 8'd2, 32'h0, 0, 0));
        wait_rsp();
        chk("err_rsp_error", rsp_error, 1);
        chk("err_err_count", err_count, 1);
        wait_rsp();
        chk("after_err_rsp_error", rsp_error, 0);
        chk("after_err_beats", rsp_beats, 3);
        chk("after_err_cmd_count", cmd_count, 4);

        push(mk(1'b0, 32'h4000, 8'd7, 32'h0, 2, 1));
        t = 0;
        while (!bus.mst_go && t < 50) begin
            @(negedge m_axi_aclk);
            t++;
        end
        hi = 0;
        while (bus.mst_go && hi < 100) begin
            hi++;
            @(negedge m_axi_aclk);
        end
        chk("timeout_go_cycles", hi, TO);
        wait_rsp();
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_error", rsp_error, 1);
        chk("to_err_count", err_count, 2);

        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(mk(1'b0, 32'h5000 + 32'(i * 16), 8'd3, 32'(i * 256), 0, 0));
        drain();
        chk("burst_saw_full", saw_not_ready, 1);

        for (int i = 0; i < 40; i++) begin
            push(mk_rand());
            repeat ($urandom_range(3, 0)) @(negedge m_axi_aclk);
        end
        drain();

        beats_driven = 0;
        push(mk(1'b0, 32'h6000, 8'd3, 32'h10, 0, 0));
        push(mk(1'b0, 32'h6100, 8'd3, 32'h20, 0, 0));
        push(mk(1'b0, 32'h6200, 8'd3, 32'h30, 0, 0));
        t = 0;
        while (beats_driven < 2 && t < 50) begin
            @(negedge m_axi_aclk);
            t++;
        end
        chk("midcmd_reached_beat2", beats_driven >= 2, 1);
        @(negedge m_axi_aclk);
        m_axi_aresetn = 1'b0;
        @(posedge m_axi_aclk);
        #2;
        chk("midrst_go_dropped", bus.mst_go, 0);
        chk("midrst_ready_low", cmd_ready, 0);
        beh_q.delete();
        exp_q.delete();
        pushed_n = 0;
        started_n = 0;
        exp_cmd = '0;
        exp_err = '0;
        @(negedge m_axi_aclk);
        m_axi_aresetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge m_axi_aclk);
            chk("midrst_no_rsp", rsp_valid, 0);
            chk("midrst_fifo_empty", bus.mst_go, 0);
        end
        chk("midrst_cmd_count", cmd_count, 0);
        chk("midrst_ready_high", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
